// File: rtl/cu_pkg.sv
// cu_pkg: shared control-unit definitions for the microprogram next-state sequencer.
package cu_pkg;
    localparam int STATE_W_DEF     = 8;
    localparam int FETCH_STATE_DEF = 1;
    localparam logic [2:0] NS_ENC    = 3'd0;
    localparam logic [2:0] NS_FETCH  = 3'd1;
    localparam logic [2:0] NS_JUMP   = 3'd2;
    localparam logic [2:0] NS_INC    = 3'd3;
    localparam logic [2:0] NS_BRANCH = 3'd4;
    localparam logic [2:0] NS_CALL   = 3'd5;
    localparam logic [2:0] NS_RET    = 3'd6;
    localparam logic [2:0] NS_WAIT   = 3'd7;
endpackage

// File: rtl/return_stack.sv
// return_stack: LIFO of microcode return addresses; push/pop ignored when full/empty.
module return_stack #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         Enable,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    logic [AW:0]  sp;
    logic [W-1:0] mem [DEPTH];
    assign full  = sp == (AW+1)'(DEPTH);
    assign empty = sp == '0;
    assign dout  = mem[AW'(sp - 1'b1)];
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sp <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (Enable) begin
            if (push && !full) begin
                mem[sp[AW-1:0]] <= din;
                sp <= sp + 1'b1;
            end else if (pop && !empty) begin
                sp <= sp - 1'b1;
            end
        end
    end
endmodule

// File: rtl/next_state_sequencer.sv
// next_state_sequencer: selects and registers the next microstore state.
// Define NEXT_STATE_SEQ_STACK_EN to enable the CALL/RET return-address stack.
module next_state_sequencer
    import cu_pkg::*;
#(
    parameter int                 STATE_W     = STATE_W_DEF,
    parameter int                 STACK_DEPTH = 4,
    parameter logic [STATE_W-1:0] FETCH_STATE = STATE_W'(FETCH_STATE_DEF)
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               Enable,
    input  logic [2:0]         NS,
    input  logic               Cond,
    input  logic               Inv,
    input  logic [STATE_W-1:0] IncState,
    input  logic [STATE_W-1:0] CRAddr,
    input  logic [STATE_W-1:0] EncAddr,
    output logic [STATE_W-1:0] State,
    output logic               StackErr
);
    logic               eff;
    logic [STATE_W-1:0] nxt;
    assign eff = Cond ^ Inv;
`ifdef NEXT_STATE_SEQ_STACK_EN
    logic               push, pop, err_set, full, empty;
    logic [STATE_W-1:0] ret_addr;
    return_stack #(.W(STATE_W), .DEPTH(STACK_DEPTH)) u_stack (
        .CLK    (CLK),
        .RESET  (RESET),
        .Enable (Enable),
        .push   (push),
        .pop    (pop),
        .din    (IncState),
        .dout   (ret_addr),
        .full   (full),
        .empty  (empty)
    );
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) StackErr <= 1'b0;
        else if (Enable && err_set) StackErr <= 1'b1;
    end
`else
    logic unused_depth;
    assign unused_depth = |STACK_DEPTH;
    assign StackErr = 1'b0;
`endif
    always_comb begin
        nxt = State;
`ifdef NEXT_STATE_SEQ_STACK_EN
        push    = 1'b0;
        pop     = 1'b0;
        err_set = 1'b0;
`endif
        case (NS)
            NS_ENC:    nxt = EncAddr;
            NS_FETCH:  nxt = FETCH_STATE;
            NS_JUMP:   nxt = CRAddr;
            NS_INC:    nxt = IncState;
            NS_BRANCH: nxt = eff ? CRAddr : IncState;
            NS_CALL: begin
                // the jump is taken even when the push overflows
                nxt = CRAddr;
`ifdef NEXT_STATE_SEQ_STACK_EN
                push    = !full;
                err_set = full;
`endif
            end
            NS_RET: begin
`ifdef NEXT_STATE_SEQ_STACK_EN
                nxt     = empty ? FETCH_STATE : ret_addr;
                pop     = !empty;
                err_set = empty;
`else
                nxt = FETCH_STATE;
`endif
            end
            default:   nxt = eff ? IncState : State;
        endcase
    end
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) State <= '0;
        else if (Enable) State <= nxt;
    end
endmodule

// File: tb/tb_next_state_sequencer.sv
// tb_next_state_sequencer: directed vector table plus multi-cycle stack/wait/reset sequences.
module tb_next_state_sequencer;
    import cu_pkg::*;
`ifdef NEXT_STATE_SEQ_STACK_EN
    localparam bit STK = 1'b1;
`else
    localparam bit STK = 1'b0;
`endif
    logic       CLK, RESET, Enable, Cond, Inv, StackErr;
    logic [2:0] NS;
    logic [7:0] IncState, CRAddr, EncAddr, State;
    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic       en;
        logic [2:0] ns;
        logic       cond;
        logic       inv;
        logic [7:0] inc;
        logic [7:0] cr;
        logic [7:0] enc;
        logic [7:0] exp_state;
    } vec_t;
    vec_t vt [12];

    next_state_sequencer dut (
        .CLK(CLK), .RESET(RESET), .Enable(Enable), .NS(NS), .Cond(Cond), .Inv(Inv),
        .IncState(IncState), .CRAddr(CRAddr), .EncAddr(EncAddr),
        .State(State), .StackErr(StackErr)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic en, input logic [2:0] ns, input logic cond, input logic inv,
                         input logic [7:0] inc, input logic [7:0] cr, input logic [7:0] enc);
        Enable = en; NS = ns; Cond = cond; Inv = inv;
        IncState = inc; CRAddr = cr; EncAddr = enc;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        #2 RESET = 1'b1;
        #2 RESET = 1'b0;
    endtask

    initial begin
        vt[0]  = '{1'b1, NS_ENC,    1'b0, 1'b0, 8'h00, 8'h00, 8'h3C, 8'h3C};
        vt[1]  = '{1'b1, NS_FETCH,  1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h01};
        vt[2]  = '{1'b1, NS_JUMP,   1'b0, 1'b0, 8'h00, 8'h23, 8'h00, 8'h23};
        vt[3]  = '{1'b1, NS_INC,    1'b0, 1'b0, 8'h05, 8'h00, 8'h00, 8'h05};
        vt[4]  = '{1'b1, NS_BRANCH, 1'b1, 1'b1, 8'h06, 8'h40, 8'h00, 8'h06};
        vt[5]  = '{1'b1, NS_BRANCH, 1'b1, 1'b0, 8'h07, 8'h40, 8'h00, 8'h40};
        vt[6]  = '{1'b1, NS_BRANCH, 1'b0, 1'b1, 8'h41, 8'h55, 8'h00, 8'h55};
        vt[7]  = '{1'b1, NS_WAIT,   1'b0, 1'b0, 8'h56, 8'h00, 8'h00, 8'h55};
        vt[8]  = '{1'b1, NS_WAIT,   1'b0, 1'b1, 8'h56, 8'h00, 8'h00, 8'h56};
        vt[9]  = '{1'b0, NS_JUMP,   1'b0, 1'b0, 8'h00, 8'hAA, 8'h00, 8'h56};
        vt[10] = '{1'b1, NS_INC,    1'b0, 1'b0, 8'hFF, 8'h00, 8'h00, 8'hFF};
        vt[11] = '{1'b1, NS_INC,    1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00};

        RESET = 1'b1;
        drive(1'b1, NS_JUMP, 1'b0, 1'b0, 8'h00, 8'h99, 8'h00);
        repeat (2) step();
        chk("reset_state", State, 8'h00);
        chk("reset_err", {7'd0, StackErr}, 8'h00);
        RESET = 1'b0;

        for (int i = 0; i < 12; i++) begin
            drive(vt[i].en, vt[i].ns, vt[i].cond, vt[i].inv, vt[i].inc, vt[i].cr, vt[i].enc);
            step();
            chk($sformatf("vec%0d_state", i), State, vt[i].exp_state);
            chk($sformatf("vec%0d_err", i), {7'd0, StackErr}, 8'h00);
        end

        // async reset mid-run with a partly filled stack and sticky error set
        drive(1'b1, NS_RET, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        step();
        chk("ret_empty_state", State, 8'h01);
        chk("ret_empty_err", {7'd0, StackErr}, {7'd0, STK});
        drive(1'b1, NS_CALL, 1'b0, 1'b0, 8'h02, 8'h23, 8'h00);
        step();
        drive(1'b1, NS_CALL, 1'b0, 1'b0, 8'h24, 8'h23, 8'h00);
        step();
        chk("pre_reset_state", State, 8'h23);
        chk("pre_reset_err", {7'd0, StackErr}, {7'd0, STK});
        #2 RESET = 1'b1;
        #1;
        chk("async_reset_state", State, 8'h00);
        chk("async_reset_err", {7'd0, StackErr}, 8'h00);
        #1 RESET = 1'b0;
        drive(1'b1, NS_RET, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        step();
        chk("post_reset_ret_state", State, 8'h01);
        chk("post_reset_ret_err", {7'd0, StackErr}, {7'd0, STK});

        // CALL immediately followed by RET
        do_reset();
        drive(1'b1, NS_CALL, 1'b0, 1'b0, 8'h11, 8'h80, 8'h00);
        step();
        chk("call_state", State, 8'h80);
        drive(1'b1, NS_RET, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        step();
        chk("ret_state", State, STK ? 8'h11 : 8'h01);
        chk("call_ret_err", {7'd0, StackErr}, 8'h00);

        // overflow on the fifth CALL, then drain past empty
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, NS_CALL, 1'b0, 1'b0, 8'h10 + 8'(i), 8'h90 + 8'(i), 8'h00);
            step();
            chk($sformatf("call%0d_state", i), State, 8'h90 + 8'(i));
            chk($sformatf("call%0d_err", i), {7'd0, StackErr}, {7'd0, STK && i == 4});
        end
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, NS_RET, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
            step();
            chk($sformatf("ret%0d_state", i), State, (STK && i < 4) ? 8'h13 - 8'(i) : 8'h01);
            chk($sformatf("ret%0d_err", i), {7'd0, StackErr}, {7'd0, STK});
        end

        // WAIT holds until eff=1; Enable=0 freezes everything
        do_reset();
        drive(1'b1, NS_JUMP, 1'b0, 1'b0, 8'h00, 8'h30, 8'h00);
        step();
        chk("wait_entry", State, 8'h30);
        drive(1'b1, NS_WAIT, 1'b0, 1'b0, 8'h31, 8'h00, 8'h00);
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("wait_hold%0d", i), State, 8'h30);
        end
        Cond = 1'b1;
        step();
        chk("wait_exit", State, 8'h31);
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 3'(i), 1'b1, 1'b0, 8'h55, 8'h77, 8'h66);
            step();
            chk($sformatf("disabled_ns%0d_state", i), State, 8'h31);
            chk($sformatf("disabled_ns%0d_err", i), {7'd0, StackErr}, 8'h00);
        end
        drive(1'b1, NS_RET, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        step();
        chk("reenable_ret_state", State, 8'h01);
        chk("reenable_ret_err", {7'd0, StackErr}, {7'd0, STK});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/next_state_sequencer.md
# next_state_sequencer

Microprogram next-state sequencer for the control unit. Each cycle it selects the next microstore state from the incrementer register output, the control-register branch target, or the instruction-decoder address. It registers the selection as the current state, which drives the microstore and the incrementer adder. An optional return-address stack supports microcode subroutines.

## Interface
- STATE_W, 8, width of microstore state/address
- STACK_DEPTH, 4, return-stack entries (power of two, ≥2)
- FETCH_STATE, 8'd1, state entered by NS=FETCH
- CLK  in  1  rising-edge clock
- RESET  in  1  asynchronous, active-high reset
- Enable  in  1  1 = advance state, 0 = hold everything
- NS  in  3  next-state select from control register
- Cond  in  1  condition from condition tester
- Inv  in  1  invert Cond (eff = Cond ^ Inv)
- IncState  in  STATE_W  incrementer register output (current state + 1)
- CRAddr  in  STATE_W  branch/call target from control register
- EncAddr  in  STATE_W  decoder state for current instruction
- State  out  STATE_W  current microstore state
- StackErr  out  1  sticky stack overflow/underflow flag

One clock; reset is asynchronous and active-high.

## Operation
- NS encoding:
  - 000 ENC: EncAddr.
  - 001 FETCH: FETCH_STATE.
  - 010 JUMP: CRAddr.
  - 011 INC: IncState.
  - 100 BRANCH: eff ? CRAddr : IncState.
  - 101 CALL: push IncState, go CRAddr.
  - 110 RET: pop to State.
  - 111 WAIT: eff ? IncState : State (hold for MOC etc.).
- Stack: LIFO of STACK_DEPTH entries, pointer SP counts 0..STACK_DEPTH.
- CALL with SP==STACK_DEPTH (full): no push, StackErr←1, jump to CRAddr still taken.
- RET with SP==0 (empty): State←FETCH_STATE, StackErr←1.
- StackErr is sticky; it clears only on RESET.
- Enable=0: State, SP, stack contents and StackErr all hold, regardless of NS.
- IncState is consumed as presented; no internal +1 arithmetic. Values wrap naturally at 2^STATE_W in the upstream adder.

## Timing
- Next-state selection is combinational from inputs in cycle n. State updates at the rising edge ending cycle n, giving 1-cycle latency.
- RESET asserted, at any time including mid-CALL or mid-RET: immediately State=0, SP=0, StackErr=0, stack entries 0.
- First edge after RESET deasserts with Enable=1 applies NS normally from state 0.
- Push and pop complete on the same edge as the State update. CALL then RET on consecutive cycles returns the pushed IncState.
- WAIT with eff=0 holds for an unbounded number of cycles. It exits on the first edge where eff=1.

## Configuration
- Macro: NEXT_STATE_SEQ_STACK_EN.
- Defined: return stack, CALL/RET semantics and StackErr as above.
- Undefined: no stack storage and no SP. CALL behaves as JUMP; RET behaves as FETCH. StackErr is tied 0.

## Structure
- Shared package cu_pkg holds:
  - NS encoding localparams (NS_ENC … NS_WAIT).
  - STATE_W default.
  - FETCH_STATE default.
- Sub-module return_stack holds the LIFO. Its ports are:
  - CLK, RESET, Enable, push, pop, din, dout, full, empty.
  - It is instantiated only under NEXT_STATE_SEQ_STACK_EN.

## Test plan
- Reset mid-run (State=8'h23, SP=2, StackErr=1), assert RESET between edges → State=0, SP=0, StackErr=0 immediately, without waiting for a clock edge.
- NS=INC with IncState=8'h05, then NS=BRANCH with Cond=1, Inv=1, CRAddr=8'h40, IncState=8'h06 → State 05 then 06 (branch not taken).
- NS=CALL with CRAddr=8'h80, IncState=8'h11, then NS=RET → State 80 then 11; StackErr stays 0.
- Five CALLs with STACK_DEPTH=4 → StackErr=1 after the fifth, State=CRAddr. Four RETs return the first four pushed values in reverse order; a fifth RET gives FETCH_STATE.
- NS=WAIT with Cond=0 for 3 cycles, then Cond=1 with IncState=8'h31 → State holds for 3 edges, then becomes 31. With Enable=0 and any NS, State holds.
- With the macro undefined: NS=CALL with CRAddr=8'h80 → State=80; NS=RET → State=FETCH_STATE; StackErr=0 throughout.
